bot_reg_sync: RTL



---
 rtl/bot_reg_pkg.sv | 21 ++
 rtl/irq_handshake.sv | 35 +++
 rtl/bot_reg_sync.sv | 104 ++++++++++
 3 files changed

// File: rtl/bot_reg_pkg.sv
// Shared definitions for the robot register synchroniser: FSM encodings,
// default widths and the {X, Y, Info} shadow-record layout.
package bot_reg_pkg;

  localparam int DEF_LOC_W  = 8;
  localparam int DEF_INFO_W = 8;
  localparam int DEF_CNT_W  = 8;

  localparam logic [1:0] S_IDLE = 2'd0;  // nothing pending
  localparam logic [1:0] S_WAIT = 2'd1;  // pending, waiting for blank
  localparam logic [1:0] S_HOLD = 2'd2;  // already committed this blank

  // Record layout at default widths; the top re-declares it with its own
  // parameter widths in the same field order.
  typedef struct packed {
    logic [DEF_LOC_W-1:0]  x;
    logic [DEF_LOC_W-1:0]  y;
    logic [DEF_INFO_W-1:0] info;
  } shadow_t;

endpackage

// File: rtl/irq_handshake.sv
// Update-interrupt flag (set by update, cleared by acknowledge, set wins)
// plus the saturating overrun counter. The counter only exists when
// BOT_REG_OVERRUN_EN is defined; otherwise overrun_cnt is tied to zero.
module irq_handshake import bot_reg_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             upd,
  input  logic             intack,
  output logic             upd_irq,
  output logic [CNT_W-1:0] overrun_cnt
);

  // Flag: an update outranks a simultaneous acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    upd_irq <= 1'b0;
    else if (upd)    upd_irq <= 1'b1;
    else if (intack) upd_irq <= 1'b0;
  end

`ifdef BOT_REG_OVERRUN_EN
  // Count updates that land while the CPU has not yet acknowledged the
  // previous one; stick at all-ones rather than wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overrun_cnt <= '0;
    else if (upd && upd_irq && (overrun_cnt != {CNT_W{1'b1}}))
      overrun_cnt <= overrun_cnt + 1'b1;
  end
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: rtl/bot_reg_sync.sv
// Rojobot register synchroniser: captures location/info on each update
// pulse into a shadow record and commits it to the display registers at
// most once per vertical blank, so the icon never tears mid-frame.
// Optional overrun counter: define BOT_REG_OVERRUN_EN.
module bot_reg_sync import bot_reg_pkg::*; #(
  parameter int LOC_W  = DEF_LOC_W,
  parameter int INFO_W = DEF_INFO_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              upd_sysregs,
  input  logic [LOC_W-1:0]  LocX_in,
  input  logic [LOC_W-1:0]  LocY_in,
  input  logic [INFO_W-1:0] BotInfo_in,
  input  logic              vblank,
  input  logic              intack,
  output logic [LOC_W-1:0]  LocX_reg,
  output logic [LOC_W-1:0]  LocY_reg,
  output logic [INFO_W-1:0] BotInfo_reg,
  output logic              upd_irq,
  output logic              commit,
  output logic [CNT_W-1:0]  overrun_cnt
);

  typedef struct packed {
    logic [LOC_W-1:0]  x;
    logic [LOC_W-1:0]  y;
    logic [INFO_W-1:0] info;
  } rec_t;

  rec_t       in_rec, shadow, cap, disp;
  logic       pending;
  logic [1:0] state, state_nxt;
  logic       do_commit;

  assign in_rec = '{x: LocX_in, y: LocY_in, info: BotInfo_in};

  // Capture mux bypasses the shadow so a pulse on the commit cycle is used.
  // Commit fires once per blank: from IDLE with a coincident pulse, or
  // from WAIT as soon as blank is seen. HOLD blocks repeats until blank ends.
  always_comb begin
    cap       = upd_sysregs ? in_rec : shadow;
    do_commit = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE: if (upd_sysregs) begin
        if (vblank) begin
          do_commit = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: if (vblank) begin
        do_commit = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: if (!vblank)
        state_nxt = (pending || upd_sysregs) ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shadow record and pending flag: latest update wins; a commit consumes
  // the pending data unless a fresh pulse arrives on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (upd_sysregs) shadow <= in_rec;
      if (do_commit)        pending <= upd_sysregs;
      else if (upd_sysregs) pending <= 1'b1;
    end
  end

  // FSM state, display registers and the one-cycle commit strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      disp   <= '0;
      commit <= 1'b0;
    end else begin
      state  <= state_nxt;
      commit <= do_commit;
      if (do_commit) disp <= cap;
    end
  end

  assign LocX_reg    = disp.x;
  assign LocY_reg    = disp.y;
  assign BotInfo_reg = disp.info;

  irq_handshake #(.CNT_W(CNT_W)) u_irq (
    .clk         (clk),
    .reset_n     (reset_n),
    .upd         (upd_sysregs),
    .intack      (intack),
    .upd_irq     (upd_irq),
    .overrun_cnt (overrun_cnt)
  );

endmodule
